// File: rtl/axis_fifo_pkg.sv
// Shared types and helpers for the AXIS FIFO family.
package axis_fifo_pkg;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_PKT  = 2'd1,
    WR_DROP = 2'd2
  } wr_state_t;

  // Pointer width including the wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/AXIS_int.sv
// AXI4-Stream bundle; clk is carried for reference only and must be the FIFO clock.
interface AXIS_int #(
  parameter int unsigned DATA_BYTES = 1,
  parameter int unsigned USER_W     = 1,
  parameter int unsigned ID_W       = 1,
  parameter int unsigned DEST_W     = 1
) (
  input logic clk
);
  logic [DATA_BYTES*8-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic [DATA_BYTES-1:0]   tstrb;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;
  logic [ID_W-1:0]         tid;
  logic [DEST_W-1:0]       tdest;
  logic [USER_W-1:0]       tuser;

  modport Master (input clk, output tdata, tkeep, tstrb, tlast, tvalid, tid, tdest, tuser, input tready);
  modport Slave  (input clk, input tdata, tkeep, tstrb, tlast, tvalid, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_fifo_out_stage.sv
// Output stage for RAM-based FIFOs: registered output or combinational bypass.
module axis_fifo_out_stage #(
  parameter int unsigned W          = 8,
  parameter int unsigned OUTPUT_REG = 1
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         empty,
  input  logic [W-1:0] rd_data,
  output logic         rd_en,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [W-1:0] m_data
);

  if (OUTPUT_REG != 0) begin : g_reg
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    // Refill when the register is free or being drained; hold while stalled.
    always_comb begin
      load    = (!valid_q || m_tready) && !empty;
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
        valid_d = 1'b1;
        data_d  = rd_data;
      end else if (m_tready) begin
        valid_d = 1'b0;
      end
    end

    // Output register state.
    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign rd_en    = load;
    assign m_tvalid = valid_q;
    assign m_data   = data_q;
  end else begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = clk ^ aresetn;
    assign m_tvalid      = !empty;
    assign m_data        = rd_data;
    assign rd_en         = !empty && m_tready;
  end

endmodule

// File: rtl/axis_dist_ram_pkt_fifo.sv
// Single-clock AXIS FIFO in distributed RAM with optional store-and-forward packet mode.
module axis_dist_ram_pkt_fifo
  import axis_fifo_pkg::*;
#(
  parameter int unsigned DEPTH              = 64,
  parameter int unsigned OUTPUT_REG         = 1,
  parameter int unsigned PACKET_MODE        = 1,
  parameter int unsigned ALLOW_BACKPRESSURE = 0,
  parameter int unsigned DROP_BAD_FRAME     = 0,
  parameter int unsigned DATA_BYTES         = 1
) (
  input  logic                     clk,
  input  logic                     aresetn,
  AXIS_int.Slave                   axis_in,
  AXIS_int.Master                  axis_out,
  output logic [ptr_w(DEPTH)-1:0]  occupancy,
  output logic [ptr_w(DEPTH)-1:0]  pkt_count,
  output logic                     drop_pulse,
  output logic                     bad_frame_pulse
);

  localparam int unsigned DL = $clog2(DEPTH);
  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned DW = DATA_BYTES * 8;
  localparam int unsigned EW = DW + DATA_BYTES + 1;

  typedef logic [PW-1:0] ptr_t;

  ptr_t      wr_cur_q, wr_cur_d, wr_commit_q, wr_commit_d, rd_ptr_q, rd_ptr_d;
  ptr_t      occupancy_q, occupancy_d, pkt_count_q, pkt_count_d;
  wr_state_t state_q, state_d;
  logic      drop_pulse_q, drop_pulse_d, bad_pulse_q, bad_pulse_d;
  logic      mem_we, commit_inc, full, empty, in_ready, accepted, bad_frame;
  logic      rd_en, m_valid, m_last, pop_last;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] rd_data, m_data;
  logic      unused_in;

  assign unused_in = ^{axis_in.tstrb, axis_in.tid, axis_in.tdest, axis_in.clk, axis_out.clk};

  assign in_ready  = (PACKET_MODE != 0 || ALLOW_BACKPRESSURE == 0) ? 1'b1 : !full;
  assign accepted  = axis_in.tvalid && in_ready;
  assign full      = (wr_cur_q - rd_ptr_q) == ptr_t'(DEPTH);
  assign empty     = rd_ptr_q == wr_commit_q;
  assign bad_frame = (DROP_BAD_FRAME != 0) && axis_in.tuser[0];
  assign pop_last  = m_valid && axis_out.tready && m_last;
  assign rd_data   = mem[rd_ptr_q[DL-1:0]];

  // Write-side policy: commit, roll back or discard incoming beats; pointer and counter updates.
  always_comb begin
    state_d      = state_q;
    wr_cur_d     = wr_cur_q;
    wr_commit_d  = wr_commit_q;
    drop_pulse_d = 1'b0;
    bad_pulse_d  = 1'b0;
    mem_we       = 1'b0;
    commit_inc   = 1'b0;
    if (PACKET_MODE != 0) begin
      if (accepted) begin
        if (state_q == WR_DROP) begin
          if (axis_in.tlast) begin
            drop_pulse_d = 1'b1;
            state_d      = WR_IDLE;
          end
        end else if (full) begin
          // Roll back the partial packet; swallow the rest of it.
          wr_cur_d = wr_commit_q;
          if (axis_in.tlast) begin
            drop_pulse_d = 1'b1;
            state_d      = WR_IDLE;
          end else begin
            state_d = WR_DROP;
          end
        end else begin
          mem_we   = 1'b1;
          wr_cur_d = wr_cur_q + ptr_t'(1);
          if (!axis_in.tlast) begin
            state_d = WR_PKT;
          end else begin
            state_d = WR_IDLE;
            if (bad_frame) begin
              wr_cur_d    = wr_commit_q;
              bad_pulse_d = 1'b1;
            end else begin
              wr_commit_d = wr_cur_q + ptr_t'(1);
              commit_inc  = 1'b1;
            end
          end
        end
      end
    end else if (accepted) begin
      if (full) begin
        drop_pulse_d = 1'b1;
      end else begin
        mem_we      = 1'b1;
        wr_cur_d    = wr_cur_q + ptr_t'(1);
        wr_commit_d = wr_cur_q + ptr_t'(1);
        commit_inc  = axis_in.tlast;
      end
    end
    rd_ptr_d    = rd_ptr_q + ptr_t'(rd_en);
    occupancy_d = wr_commit_d - rd_ptr_d;
    pkt_count_d = pkt_count_q + ptr_t'(commit_inc) - ptr_t'(pop_last);
  end

  // Control state; a reset discards all stored data, committed or not.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= WR_IDLE;
      wr_cur_q     <= '0;
      wr_commit_q  <= '0;
      rd_ptr_q     <= '0;
      occupancy_q  <= '0;
      pkt_count_q  <= '0;
      drop_pulse_q <= 1'b0;
      bad_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cur_q     <= wr_cur_d;
      wr_commit_q  <= wr_commit_d;
      rd_ptr_q     <= rd_ptr_d;
      occupancy_q  <= occupancy_d;
      pkt_count_q  <= pkt_count_d;
      drop_pulse_q <= drop_pulse_d;
      bad_pulse_q  <= bad_pulse_d;
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_cur_q[DL-1:0]] <= {axis_in.tdata, axis_in.tkeep, axis_in.tlast};
    end
  end

  axis_fifo_out_stage #(
    .W          (EW),
    .OUTPUT_REG (OUTPUT_REG)
  ) u_out_stage (
    .clk      (clk),
    .aresetn  (aresetn),
    .empty    (empty),
    .rd_data  (rd_data),
    .rd_en    (rd_en),
    .m_tvalid (m_valid),
    .m_tready (axis_out.tready),
    .m_data   (m_data)
  );

  assign {axis_out.tdata, axis_out.tkeep, m_last} = m_data;
  assign axis_out.tlast  = m_last;
  assign axis_out.tvalid = m_valid;
  assign axis_out.tstrb  = '1;
  assign axis_out.tid    = '0;
  assign axis_out.tdest  = '0;
  assign axis_out.tuser  = '0;
  assign axis_in.tready  = in_ready;

  assign occupancy       = occupancy_q;
  assign pkt_count       = pkt_count_q;
  assign drop_pulse      = drop_pulse_q;
  assign bad_frame_pulse = bad_pulse_q;

endmodule

// File: tb/tb_axis_dist_ram_pkt_fifo.sv
// Bench: packet-mode instance (DEPTH 16, registered output, bad-frame drop) and
// word-mode instance (DEPTH 8, bypass output, overflow discard) against queue models.
module tb_axis_dist_ram_pkt_fifo;

  typedef struct packed {
    logic       last;
    logic       keep;
    logic [7:0] data;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic aresetn, w_aresetn;
  AXIS_int #(.DATA_BYTES(1)) p_in  (.clk(clk));
  AXIS_int #(.DATA_BYTES(1)) p_out (.clk(clk));
  AXIS_int #(.DATA_BYTES(1)) w_in  (.clk(clk));
  AXIS_int #(.DATA_BYTES(1)) w_out (.clk(clk));

  logic [4:0] p_occ, p_pkts;
  logic       p_drop, p_bad;
  logic [3:0] w_occ, w_pkts;
  logic       w_drop, w_bad;

  axis_dist_ram_pkt_fifo #(
    .DEPTH(16), .OUTPUT_REG(1), .PACKET_MODE(1),
    .ALLOW_BACKPRESSURE(0), .DROP_BAD_FRAME(1), .DATA_BYTES(1)
  ) u_pkt (
    .clk(clk), .aresetn(aresetn), .axis_in(p_in), .axis_out(p_out),
    .occupancy(p_occ), .pkt_count(p_pkts), .drop_pulse(p_drop), .bad_frame_pulse(p_bad)
  );

  axis_dist_ram_pkt_fifo #(
    .DEPTH(8), .OUTPUT_REG(0), .PACKET_MODE(0),
    .ALLOW_BACKPRESSURE(0), .DROP_BAD_FRAME(0), .DATA_BYTES(1)
  ) u_word (
    .clk(clk), .aresetn(w_aresetn), .axis_in(w_in), .axis_out(w_out),
    .occupancy(w_occ), .pkt_count(w_pkts), .drop_pulse(w_drop), .bad_frame_pulse(w_bad)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- packet-mode instance ----------------
  beat_t exp_q[$];
  int    rdy_mode  = 0;   // 0 hold low, 1 hold high, 2 random
  logic  occ_watch = 1'b0;

  initial begin
    p_out.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       p_out.tready = 1'b0;
        1:       p_out.tready = 1'b1;
        default: p_out.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    beat_t b;
    if (p_out.tvalid === 1'b1 && p_out.tready === 1'b1) begin
      check_eq("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        check_eq("out_data", p_out.tdata, b.data);
        check_eq("out_keep", p_out.tkeep, b.keep);
        check_eq("out_last", p_out.tlast, b.last);
      end
    end
    if (occ_watch) check_eq("occ_le_depth", p_occ <= 16, 1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic p_beat(input logic [7:0] d, input logic k, input logic l, input logic u);
    p_in.tdata  = d;
    p_in.tkeep  = k;
    p_in.tlast  = l;
    p_in.tuser  = u;
    p_in.tvalid = 1'b1;
    @(posedge clk);
    #1;
    p_in.tvalid = 1'b0;
  endtask

  // fits: the packet has room in the RAM for every beat at the time it is written.
  task automatic send_pkt(input int len, input logic bad, input logic fits, input int max_gap);
    beat_t b;
    beat_t pk[$];
    for (int i = 0; i < len; i++) begin
      b.data = 8'($urandom);
      b.keep = 1'($urandom_range(0, 1));
      b.last = (i == len - 1);
      pk.push_back(b);
    end
    if (fits && !bad) foreach (pk[i]) exp_q.push_back(pk[i]);
    for (int i = 0; i < len; i++) begin
      p_beat(pk[i].data, pk[i].keep, pk[i].last, (i == len - 1) ? bad : 1'b0);
      if (i == len - 1) begin
        check_eq("drop_pulse_last", p_drop, !fits);
        check_eq("bad_pulse_last", p_bad, fits && bad);
      end else begin
        check_eq("drop_pulse_mid", p_drop, 0);
        if (max_gap > 0) idle($urandom_range(0, max_gap));
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) idle(1);
    idle(3);
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- word-mode instance ----------------
  logic [8:0] w_q[$];
  int         w_pk = 0;
  logic       w_drop_exp = 1'b0;
  logic       w_run = 1'b0;
  logic       w_done = 1'b0;

  always @(negedge clk) begin
    int n;
    if (w_run) begin
      check_eq("w_occ", w_occ, w_q.size());
      check_eq("w_valid", w_out.tvalid, w_q.size() != 0);
      check_eq("w_pkts", w_pkts, w_pk);
      check_eq("w_drop", w_drop, w_drop_exp);
      check_eq("w_ready", w_in.tready, 1);
      check_eq("w_bad", w_bad, 0);
      if (w_q.size() != 0) check_eq("w_data", {w_out.tlast, w_out.tdata}, w_q[0]);
      n = w_q.size();
      w_drop_exp = 1'b0;
      if (n != 0 && w_out.tready) begin
        if (w_q[0][8]) w_pk--;
        void'(w_q.pop_front());
      end
      if (w_in.tvalid) begin
        if (n == 8) w_drop_exp = 1'b1;
        else begin
          w_q.push_back({w_in.tlast, w_in.tdata});
          if (w_in.tlast) w_pk++;
        end
      end
    end
  end

  initial begin
    w_aresetn = 1'b0;
    w_in.tvalid = 1'b0; w_in.tdata = '0; w_in.tkeep = '1; w_in.tlast = 1'b0;
    w_in.tuser = '0; w_in.tstrb = '0; w_in.tid = '0; w_in.tdest = '0;
    w_out.tready = 1'b0;
    idle(3);
    w_aresetn = 1'b1;
    w_run = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      w_in.tvalid  = ($urandom_range(0, 2) != 0);
      w_in.tdata   = 8'($urandom);
      w_in.tlast   = ($urandom_range(0, 3) == 0);
      w_out.tready = (c < 200) ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    w_in.tvalid  = 1'b0;
    w_out.tready = 1'b1;
    idle(20);
    w_done = 1'b1;
  end

  // ---------------- main sequence ----------------
  initial begin
    int len;
    logic bad;
    aresetn = 1'b0;
    p_in.tvalid = 1'b0; p_in.tdata = '0; p_in.tkeep = '0; p_in.tlast = 1'b0;
    p_in.tuser = '0; p_in.tstrb = '0; p_in.tid = '0; p_in.tdest = '0;
    idle(3);
    check_eq("rst_tvalid", p_out.tvalid, 0);
    check_eq("rst_tlast", p_out.tlast, 0);
    check_eq("rst_occ", p_occ, 0);
    check_eq("rst_pkts", p_pkts, 0);
    check_eq("rst_drop", p_drop, 0);
    check_eq("rst_bad", p_bad, 0);
    check_eq("rst_in_ready", p_in.tready, 1);
    aresetn = 1'b1;
    idle(2);

    // 4-beat packet, sink always ready.
    rdy_mode = 1;
    idle(2);
    for (int i = 0; i < 4; i++) exp_q.push_back('{last: (i == 3), keep: 1'b1, data: 8'(8'h40 + i)});
    for (int i = 0; i < 4; i++) begin
      p_beat(8'(8'h40 + i), 1'b1, i == 3, 1'b0);
      if (i < 3) check_eq("t1_no_early_valid", p_out.tvalid, 0);
      else begin
        check_eq("t1_pkts_commit", p_pkts, 1);
        check_eq("t1_valid_commit_edge", p_out.tvalid, 0);
      end
    end
    idle(1);
    check_eq("t1_valid_latency", p_out.tvalid, 1);
    wait_drain();
    check_eq("t1_pkts_after", p_pkts, 0);
    check_eq("t1_occ_after", p_occ, 0);

    // Nearly full FIFO: 15 committed beats (one parked in the output register), then overflow.
    rdy_mode = 0;
    idle(2);
    send_pkt(15, 1'b0, 1'b1, 0);
    idle(3);
    check_eq("t2_occ_before", p_occ, 14);
    check_eq("t2_pkts_before", p_pkts, 1);
    send_pkt(4, 1'b0, 1'b0, 0);
    idle(1);
    check_eq("t2_drop_one_cycle", p_drop, 0);
    check_eq("t2_occ_after", p_occ, 14);
    check_eq("t2_pkts_after", p_pkts, 1);
    rdy_mode = 1;
    wait_drain();

    // Packet longer than DEPTH drops; following packet is delivered.
    send_pkt(20, 1'b0, 1'b0, 0);
    idle(2);
    check_eq("t3_occ", p_occ, 0);
    check_eq("t3_pkts", p_pkts, 0);
    send_pkt(2, 1'b0, 1'b1, 0);
    wait_drain();

    // Bad frame is discarded whole.
    send_pkt(3, 1'b1, 1'b1, 0);
    idle(4);
    check_eq("t4_pkts", p_pkts, 0);
    check_eq("t4_no_output", p_out.tvalid, 0);
    check_eq("t4_occ", p_occ, 0);

    // Random sink stalls over a 10-packet stream, some bad frames.
    rdy_mode = 2;
    occ_watch = 1'b1;
    for (int k = 0; k < 10; k++) begin
      len = $urandom_range(1, 8);
      bad = ($urandom_range(0, 4) == 0);
      for (int t = 0; t < 500 && (int'(p_occ) + len > 16); t++) idle(1);
      check_eq("t5_space", int'(p_occ) + len <= 16, 1);
      send_pkt(len, bad, 1'b1, 2);
    end
    rdy_mode = 1;
    wait_drain();
    occ_watch = 1'b0;

    // Reset in the middle of a packet with committed data waiting.
    rdy_mode = 0;
    idle(2);
    send_pkt(3, 1'b0, 1'b1, 0);
    p_beat(8'hA1, 1'b1, 1'b0, 1'b0);
    p_beat(8'hA2, 1'b1, 1'b0, 1'b0);
    #2;
    check_eq("t6_pre_rst_valid", p_out.tvalid, 1);
    check_eq("t6_pre_rst_occ", p_occ, 2);
    aresetn = 1'b0;
    #1;
    check_eq("t6_rst_valid", p_out.tvalid, 0);
    check_eq("t6_rst_last", p_out.tlast, 0);
    check_eq("t6_rst_occ", p_occ, 0);
    check_eq("t6_rst_pkts", p_pkts, 0);
    exp_q.delete();
    idle(2);
    aresetn = 1'b1;
    rdy_mode = 1;
    idle(2);
    send_pkt(4, 1'b0, 1'b1, 0);
    wait_drain();
    check_eq("t6_pkts_after", p_pkts, 0);

    for (int t = 0; t < 2000 && !w_done; t++) idle(1);
    check_eq("w_done", w_done, 1);
    w_run = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
